// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the architectural HI/LO pair.
// Uses radix-2 shift-add multiply and restoring divide over WIDTH iterations, then a sign-fix cycle.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;

  logic               div_q, sa_q, sb_q, dz_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               accept, sgn, last;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum, trial;
  logic [2*WIDTH-1:0] mul_nx, div_nx, prod;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // op[0]=0 selects the signed forms; op[1]=1 selects divide.
  assign sgn    = ~op[0];
  assign accept = (state == IDLE) & start & ~flush;
  assign abs_a  = (sgn & opa[WIDTH-1]) ? -opa : opa;
  assign abs_b  = (sgn & opb[WIDTH-1]) ? -opb : opb;
  assign last   = (cnt == CW'(WIDTH-1));

  assign busy  = (state != IDLE);
  assign stall = busy | (start & ~flush);

  // a_q is the multiplicand or divisor; acc holds {upper,lower} or {rem,quot}.
  assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
  assign trial  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, a_q};
  assign mul_nx = b_q[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
  assign div_nx = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod  = (sa_q ^ sb_q) ? -acc : acc;
  assign q_fix = (sa_q ^ sb_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (op[1] && opb == '0) ? FIX : CALC;
      CALC: if (last) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        div_q <= op[1];
        sa_q  <= sgn & opa[WIDTH-1];
        sb_q  <= sgn & opb[WIDTH-1];
        dz_q  <= op[1] & (opb == '0);
        a_q   <= op[1] ? abs_b : abs_a;
        b_q   <= abs_b;
        acc   <= op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
        cnt   <= '0;
      end else if (state == IDLE && !start) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end else if (state == CALC && !flush) begin
        acc <= div_q ? div_nx : mul_nx;
        b_q <= b_q >> 1;
        cnt <= cnt + 1'b1;
      end else if (state == FIX && !flush) begin
        done <= 1'b1;
        if (!dz_q) begin
          if (div_q) begin
            lo <= q_fix;
            hi <= r_fix;
          end else begin
            {hi, lo} <= prod;
          end
        end
      end
    end
  end
endmodule
